// File: rtl/rbt_pkg.sv
// Shared constants for the RBT header extractor: FSM encoding, header beat count, length saturation.
package rbt_pkg;

  // Extractor FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;  // waiting for the first beat of a packet
  localparam logic [1:0] ST_HDR  = 2'd1;  // capturing header beats 1..HDR_BEATS-1
  localparam logic [1:0] ST_BODY = 2'd2;  // header full, beats are only counted and forwarded

  // Packet length saturates here; the 17th adder bit flags overflow
  localparam logic [15:0] LEN_SAT = 16'hFFFF;

  // Header beat count for the default 2048-bit header over a 512-bit stream
  localparam int HDR_BEATS_DEFAULT = 4;

  // Number of stream beats that make up one captured header
  function automatic int hdr_beats(input int header_width, input int data_width);
    return header_width / data_width;
  endfunction

endpackage

// File: rtl/rbt_keep_popcount.sv
// Combinational tkeep-to-byte-count reducer; no contiguity assumed on tkeep.
module rbt_keep_popcount #(
  parameter int KEEP_WIDTH = 64,
  parameter int CNT_W      = $clog2(KEEP_WIDTH + 1)
) (
  input  logic [KEEP_WIDTH-1:0] keep_i,
  output logic [CNT_W-1:0]      cnt_o
);

  // Sum every tkeep bit into the byte count
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      cnt_o = cnt_o + CNT_W'(keep_i[i]);
    end
  end

endmodule

// File: rtl/rbt_s_hdr_extractor.sv
// Forwards an AXI-Stream packet unchanged (1-cycle register stage) while capturing the first
// HEADER_WIDTH bits, the saturated byte length and the first-beat tuser/meta for the pre-parser.
module rbt_s_hdr_extractor
  import rbt_pkg::*;
#(
  parameter int DATA_WIDTH   = 512,
  parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
  parameter int HEADER_WIDTH = 2048,
  parameter int USER_WIDTH   = 36,
  parameter int META_WIDTH   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]   s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  input  logic [USER_WIDTH-1:0]   s_axis_tuser,
  output logic                    s_axis_tready,
  input  logic [META_WIDTH-1:0]   in_meta,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]   m_axis_tkeep,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  output logic [USER_WIDTH-1:0]   m_axis_tuser,
  input  logic                    m_axis_tready,
  output logic                    out_proto_hdr_valid,
  input  logic                    out_proto_hdr_ready,
  output logic [15:0]             out_proto_hdr_length,
  output logic [15:0]             out_proto_hdr_pktlen,
  output logic [HEADER_WIDTH-1:0] out_proto_hdr_data,
  output logic [USER_WIDTH-1:0]   out_proto_hdr_tuser,
  output logic [META_WIDTH-1:0]   out_proto_hdr_meta
);

  localparam int          HDR_BEATS = hdr_beats(HEADER_WIDTH, DATA_WIDTH);
  localparam int          IDX_W     = (HDR_BEATS > 1) ? $clog2(HDR_BEATS) : 1;
  localparam int          CNT_W     = $clog2(KEEP_WIDTH + 1);
  localparam logic [15:0] HDR_BYTES = 16'(HEADER_WIDTH / 8);

  logic [1:0]              state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d, cur_idx;
  logic [HEADER_WIDTH-1:0] hdr_q, hdr_d;
  logic [15:0]             len_q, len_d;
  logic [USER_WIDTH-1:0]   tuser_q, tuser_d;
  logic [META_WIDTH-1:0]   meta_q, meta_d;
  logic [CNT_W-1:0]        keep_cnt;
  logic [DATA_WIDTH-1:0]   beat_masked;
  logic [16:0]             len_sum;
  logic                    first, accept, hdr_block, tready;

  logic                    m_tvalid_q;
  logic                    hv_q;

  rbt_keep_popcount #(
    .KEEP_WIDTH (KEEP_WIDTH),
    .CNT_W      (CNT_W)
  ) u_popcount (
    .keep_i (s_axis_tkeep),
    .cnt_o  (keep_cnt)
  );

  // A tlast beat must not overwrite a header that is still waiting for its consumer
  assign hdr_block     = s_axis_tvalid && s_axis_tlast && hv_q && !out_proto_hdr_ready;
  assign tready        = (!m_tvalid_q || m_axis_tready) && !hdr_block && !rst;
  assign s_axis_tready = tready;
  assign accept        = s_axis_tvalid && tready;
  assign first         = (state_q == ST_IDLE);
  assign cur_idx       = first ? '0 : idx_q;
  assign len_sum       = {1'b0, (first ? 16'h0000 : len_q)} + 17'(keep_cnt);

  // Zero the bytes that tkeep marks as absent before they enter the header
  always_comb begin
    beat_masked = '0;
    for (int b = 0; b < KEEP_WIDTH; b++) begin
      beat_masked[b*8 +: 8] = s_axis_tkeep[b] ? s_axis_tdata[b*8 +: 8] : 8'h00;
    end
  end

  // Next-state for the FSM and the per-packet accumulators
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hdr_d   = hdr_q;
    len_d   = len_q;
    tuser_d = tuser_q;
    meta_d  = meta_q;
    if (accept) begin
      len_d = len_sum[16] ? LEN_SAT : len_sum[15:0];
      if (first) begin
        hdr_d   = '0;
        tuser_d = s_axis_tuser;
        meta_d  = in_meta;
      end
      if (state_q != ST_BODY) begin
        for (int i = 0; i < HDR_BEATS; i++) begin
          if (IDX_W'(i) == cur_idx) hdr_d[i*DATA_WIDTH +: DATA_WIDTH] = beat_masked;
        end
      end
      case (state_q)
        ST_IDLE: begin
          idx_d   = IDX_W'(1);
          state_d = (HDR_BEATS == 1) ? ST_BODY : ST_HDR;
        end
        ST_HDR: begin
          if (idx_q == IDX_W'(HDR_BEATS - 1)) state_d = ST_BODY;
          else                                idx_d   = idx_q + IDX_W'(1);
        end
        default: ;
      endcase
      if (s_axis_tlast) state_d = ST_IDLE;
    end
  end

  // FSM and accumulator registers; a reset discards any partial packet
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      hdr_q   <= '0;
      len_q   <= '0;
      tuser_q <= '0;
      meta_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hdr_q   <= hdr_d;
      len_q   <= len_d;
      tuser_q <= tuser_d;
      meta_q  <= meta_d;
    end
  end

  // Header output: load on tlast acceptance (wins over a same-cycle handshake), else drain
  always_ff @(posedge clk) begin
    if (rst) begin
      hv_q                 <= 1'b0;
      out_proto_hdr_data   <= '0;
      out_proto_hdr_pktlen <= '0;
      out_proto_hdr_length <= '0;
      out_proto_hdr_tuser  <= '0;
      out_proto_hdr_meta   <= '0;
    end else if (accept && s_axis_tlast) begin
      hv_q                 <= 1'b1;
      out_proto_hdr_data   <= hdr_d;
      out_proto_hdr_pktlen <= len_d;
      out_proto_hdr_length <= (len_d > HDR_BYTES) ? HDR_BYTES : len_d;
      out_proto_hdr_tuser  <= tuser_d;
      out_proto_hdr_meta   <= meta_d;
    end else if (out_proto_hdr_ready) begin
      hv_q <= 1'b0;
    end
  end

  assign out_proto_hdr_valid = hv_q;

  // Output stream valid: refill whenever the slot is free or being drained
  always_ff @(posedge clk) begin
    if (rst) begin
      m_tvalid_q <= 1'b0;
    end else if (!m_tvalid_q || m_axis_tready) begin
      m_tvalid_q <= accept;
    end
  end

  // Output stream payload: captured on every accepted beat
  always_ff @(posedge clk) begin
    if (accept) begin
      m_axis_tdata <= s_axis_tdata;
      m_axis_tkeep <= s_axis_tkeep;
      m_axis_tlast <= s_axis_tlast;
      m_axis_tuser <= s_axis_tuser;
    end
  end

  assign m_axis_tvalid = m_tvalid_q;

endmodule

// File: tb/tb_rbt_s_hdr_extractor.sv
// Directed bench for rbt_s_hdr_extractor with hand-computed expectations.
module tb_rbt_s_hdr_extractor;

  logic          clk = 1'b0;
  logic          rst;
  logic [511:0]  s_axis_tdata;
  logic [63:0]   s_axis_tkeep;
  logic          s_axis_tvalid;
  logic          s_axis_tlast;
  logic [35:0]   s_axis_tuser;
  logic          s_axis_tready;
  logic [31:0]   in_meta;
  logic [511:0]  m_axis_tdata;
  logic [63:0]   m_axis_tkeep;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic [35:0]   m_axis_tuser;
  logic          m_axis_tready;
  logic          out_proto_hdr_valid;
  logic          out_proto_hdr_ready;
  logic [15:0]   out_proto_hdr_length;
  logic [15:0]   out_proto_hdr_pktlen;
  logic [2047:0] out_proto_hdr_data;
  logic [35:0]   out_proto_hdr_tuser;
  logic [31:0]   out_proto_hdr_meta;

  rbt_s_hdr_extractor dut (
    .clk                  (clk),
    .rst                  (rst),
    .s_axis_tdata         (s_axis_tdata),
    .s_axis_tkeep         (s_axis_tkeep),
    .s_axis_tvalid        (s_axis_tvalid),
    .s_axis_tlast         (s_axis_tlast),
    .s_axis_tuser         (s_axis_tuser),
    .s_axis_tready        (s_axis_tready),
    .in_meta              (in_meta),
    .m_axis_tdata         (m_axis_tdata),
    .m_axis_tkeep         (m_axis_tkeep),
    .m_axis_tvalid        (m_axis_tvalid),
    .m_axis_tlast         (m_axis_tlast),
    .m_axis_tuser         (m_axis_tuser),
    .m_axis_tready        (m_axis_tready),
    .out_proto_hdr_valid  (out_proto_hdr_valid),
    .out_proto_hdr_ready  (out_proto_hdr_ready),
    .out_proto_hdr_length (out_proto_hdr_length),
    .out_proto_hdr_pktlen (out_proto_hdr_pktlen),
    .out_proto_hdr_data   (out_proto_hdr_data),
    .out_proto_hdr_tuser  (out_proto_hdr_tuser),
    .out_proto_hdr_meta   (out_proto_hdr_meta)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [511:0] data;
    logic [63:0]  keep;
    logic         last;
    int           cyc;
  } beat_rec_t;

  typedef struct {
    logic [15:0]   pktlen;
    logic [15:0]   length;
    logic [2047:0] data;
    logic [35:0]   tuser;
    logic [31:0]   meta;
    int            cyc;
  } hdr_rec_t;

  beat_rec_t out_q[$];
  hdr_rec_t  hq[$];

  int n_checks = 0;
  int n_errors = 0;

  // Record stream beats and header handshakes away from the active edge
  always @(negedge clk) begin
    if (m_axis_tvalid && m_axis_tready)
      out_q.push_back('{m_axis_tdata, m_axis_tkeep, m_axis_tlast, cyc});
    if (out_proto_hdr_valid && out_proto_hdr_ready)
      hq.push_back('{out_proto_hdr_pktlen, out_proto_hdr_length, out_proto_hdr_data,
                     out_proto_hdr_tuser, out_proto_hdr_meta, cyc});
  end

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] beat_pat(input int i);
    return {16{32'hCAFE_0000 + 32'(i)}};
  endfunction

  // Offer one beat and return the cycle index whose closing edge accepts it
  task automatic send_beat(input logic [511:0] d, input logic [63:0] k, input logic l,
                           input logic [35:0] u, input logic [31:0] m, output int acc_cyc);
    int n;
    n = 0;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tuser  = u;
    in_meta       = m;
    s_axis_tvalid = 1'b1;
    #1;
    while (!s_axis_tready && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    if (!s_axis_tready) begin
      check("accept_timeout", 512'(s_axis_tready), 512'd1);
      acc_cyc = -1;
    end else begin
      acc_cyc = cyc;
    end
    @(negedge clk);
  endtask

  task automatic idle_in();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int c0, c1, c2;
  int inc[6];

  initial begin
    rst = 1'b1;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    s_axis_tuser = '0; in_meta = '0; m_axis_tready = 1'b1; out_proto_hdr_ready = 1'b0;
    settle(2);
    #1;
    check("rst_tready",   512'(s_axis_tready), 512'd0);
    check("rst_m_valid",  512'(m_axis_tvalid), 512'd0);
    check("rst_h_valid",  512'(out_proto_hdr_valid), 512'd0);
    check("rst_pktlen",   512'(out_proto_hdr_pktlen), 512'd0);
    check("rst_length",   512'(out_proto_hdr_length), 512'd0);
    check("rst_hdr_slot0", out_proto_hdr_data[511:0], 512'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_tready", 512'(s_axis_tready), 512'd1);

    // 1-beat packet, 32 kept bytes
    @(negedge clk);
    out_proto_hdr_ready = 1'b1;
    out_q.delete(); hq.delete();
    send_beat({8{64'h0123_4567_89AB_CDEF}}, 64'h0000_0000_FFFF_FFFF, 1'b1,
              36'h1_2345_6789, 32'hDEAD_0001, c0);
    idle_in();
    settle(3);
    check("t1_hdr_count", 512'(hq.size()), 512'd1);
    check("t1_out_count", 512'(out_q.size()), 512'd1);
    if (hq.size() >= 1) begin
      check("t1_hdr_cyc", 512'(hq[0].cyc), 512'(c0 + 1));
      check("t1_pktlen",  512'(hq[0].pktlen), 512'd32);
      check("t1_length",  512'(hq[0].length), 512'd32);
      check("t1_slot0",   hq[0].data[511:0], {256'h0, {4{64'h0123_4567_89AB_CDEF}}});
      check("t1_slot1",   hq[0].data[1023:512], 512'd0);
      check("t1_slot2",   hq[0].data[1535:1024], 512'd0);
      check("t1_slot3",   hq[0].data[2047:1536], 512'd0);
      check("t1_tuser",   512'(hq[0].tuser), 512'h1_2345_6789);
      check("t1_meta",    512'(hq[0].meta), 512'hDEAD_0001);
    end
    if (out_q.size() >= 1) begin
      check("t1_out_cyc",  512'(out_q[0].cyc), 512'(c0 + 1));
      check("t1_out_last", 512'(out_q[0].last), 512'd1);
      check("t1_out_data", out_q[0].data, {8{64'h0123_4567_89AB_CDEF}});
    end

    // 6-beat full packet, 384 bytes; tuser/meta on later beats must be ignored
    out_q.delete(); hq.delete();
    for (int i = 0; i < 6; i++) begin
      send_beat(beat_pat(i), {64{1'b1}}, (i == 5),
                (i == 0) ? 36'hA_0000_0002 : 36'hF_FFFF_FFFF,
                (i == 0) ? 32'hBEEF_0002 : 32'h5555_5555, inc[i]);
    end
    idle_in();
    settle(3);
    check("t2_hdr_count", 512'(hq.size()), 512'd1);
    check("t2_out_count", 512'(out_q.size()), 512'd6);
    if (hq.size() >= 1) begin
      check("t2_pktlen", 512'(hq[0].pktlen), 512'd384);
      check("t2_length", 512'(hq[0].length), 512'd256);
      for (int s = 0; s < 4; s++) check($sformatf("t2_slot%0d", s), hq[0].data[s*512 +: 512], beat_pat(s));
      check("t2_tuser",  512'(hq[0].tuser), 512'hA_0000_0002);
      check("t2_meta",   512'(hq[0].meta), 512'hBEEF_0002);
      check("t2_hdr_cyc", 512'(hq[0].cyc), 512'(inc[5] + 1));
    end
    if (out_q.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        check($sformatf("t2_out%0d_data", i), out_q[i].data, beat_pat(i));
        check($sformatf("t2_out%0d_keep", i), 512'(out_q[i].keep), 512'(64'hFFFF_FFFF_FFFF_FFFF));
        check($sformatf("t2_out%0d_last", i), 512'(out_q[i].last), 512'(i == 5));
        check($sformatf("t2_out%0d_cyc", i),  512'(out_q[i].cyc), 512'(inc[i] + 1));
      end
    end

    // Header consumer stalled: second tlast must wait for the first header
    out_proto_hdr_ready = 1'b0;
    send_beat({64{8'h11}}, {64{1'b1}}, 1'b1, 36'h0_0000_00AA, 32'h0000_00AA, c0);
    idle_in();
    settle(2);
    s_axis_tdata = {64{8'h22}}; s_axis_tkeep = 64'h0000_0000_0000_FFFF; s_axis_tlast = 1'b1;
    s_axis_tuser = 36'h0_0000_00BB; in_meta = 32'h0000_00BB; s_axis_tvalid = 1'b1;
    #1;
    check("t3_stall_tready", 512'(s_axis_tready), 512'd0);
    settle(3);
    #1;
    check("t3_stall_tready_late", 512'(s_axis_tready), 512'd0);
    check("t3_held_valid",  512'(out_proto_hdr_valid), 512'd1);
    check("t3_held_pktlen", 512'(out_proto_hdr_pktlen), 512'd64);
    check("t3_held_meta",   512'(out_proto_hdr_meta), 512'hAA);
    out_proto_hdr_ready = 1'b1;
    #1;
    check("t3_release_tready", 512'(s_axis_tready), 512'd1);
    @(negedge clk);
    idle_in();
    #1;
    check("t3_second_valid",  512'(out_proto_hdr_valid), 512'd1);
    check("t3_second_pktlen", 512'(out_proto_hdr_pktlen), 512'd16);
    check("t3_second_length", 512'(out_proto_hdr_length), 512'd16);
    check("t3_second_tuser",  512'(out_proto_hdr_tuser), 512'hBB);
    check("t3_second_slot0",  out_proto_hdr_data[511:0], {384'h0, {16{8'h22}}});
    @(negedge clk); #1;
    check("t3_drained", 512'(out_proto_hdr_valid), 512'd0);

    // Back-to-back 1-beat packets with the consumer always ready: no bubble
    @(negedge clk);
    hq.delete();
    send_beat({64{8'h5A}}, 64'h0000_0000_0000_0001, 1'b1, 36'h1, 32'h1, c0);
    send_beat({64{8'h5A}}, 64'h8000_0000_0000_0003, 1'b1, 36'h2, 32'h2, c1);
    send_beat({64{8'h5A}}, 64'h0000_0000_0000_0000, 1'b1, 36'h3, 32'h3, c2);
    idle_in();
    settle(3);
    check("t4_hdr_count", 512'(hq.size()), 512'd3);
    if (hq.size() == 3) begin
      check("t4_cyc0",    512'(hq[0].cyc), 512'(c0 + 1));
      check("t4_cyc1",    512'(hq[1].cyc), 512'(hq[0].cyc + 1));
      check("t4_cyc2",    512'(hq[2].cyc), 512'(hq[1].cyc + 1));
      check("t4_pktlen0", 512'(hq[0].pktlen), 512'd1);
      check("t4_pktlen1", 512'(hq[1].pktlen), 512'd3);
      check("t4_pktlen2", 512'(hq[2].pktlen), 512'd0);
      check("t4_slot1",   hq[1].data[511:0], {8'h5A, 488'h0, 16'h5A5A});
      check("t4_meta2",   512'(hq[2].meta), 512'd3);
    end

    // Reset after beat 2 of a 5-beat packet, then a fresh 1-beat packet
    hq.delete();
    for (int i = 0; i < 3; i++)
      send_beat(beat_pat(10 + i), {64{1'b1}}, 1'b0, 36'h7, 32'h7, c0);
    rst = 1'b1;
    s_axis_tlast = 1'b1;
    #1;
    check("t5_rst_tready", 512'(s_axis_tready), 512'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_in();
    #1;
    check("t5_rst_h_valid", 512'(out_proto_hdr_valid), 512'd0);
    check("t5_rst_m_valid", 512'(m_axis_tvalid), 512'd0);
    check("t5_rst_pktlen",  512'(out_proto_hdr_pktlen), 512'd0);
    settle(2);
    check("t5_no_hdr", 512'(hq.size()), 512'd0);
    send_beat({8{64'hFEDC_BA98_7654_3210}}, 64'h0000_0000_0000_00FF, 1'b1,
              36'hC_0000_0005, 32'hF00D_0005, c0);
    idle_in();
    settle(3);
    check("t5_hdr_count", 512'(hq.size()), 512'd1);
    if (hq.size() >= 1) begin
      check("t5_pktlen", 512'(hq[0].pktlen), 512'd8);
      check("t5_length", 512'(hq[0].length), 512'd8);
      check("t5_tuser",  512'(hq[0].tuser), 512'hC_0000_0005);
      check("t5_meta",   512'(hq[0].meta), 512'hF00D_0005);
      check("t5_slot0",  hq[0].data[511:0], {448'h0, 64'hFEDC_BA98_7654_3210});
      check("t5_slot1",  hq[0].data[1023:512], 512'd0);
    end

    // 1100 full beats: 70400 bytes saturates the length
    hq.delete();
    for (int i = 0; i < 1100; i++)
      send_beat(beat_pat(i), {64{1'b1}}, (i == 1099), 36'h9, 32'h9, c0);
    idle_in();
    settle(3);
    check("t6_hdr_count", 512'(hq.size()), 512'd1);
    if (hq.size() >= 1) begin
      check("t6_pktlen", 512'(hq[0].pktlen), 512'd65535);
      check("t6_length", 512'(hq[0].length), 512'd256);
      check("t6_slot3",  hq[0].data[2047:1536], beat_pat(3));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
